wb_config_sequencer: RTL and testbench

WB_CONFIG_SEQUENCER -- requirements
Module: wb_config_sequencer

---
 rtl/wb_config_sequencer.sv | 160 ++++++++++++++++
 tb/tb_wb_config_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_config_sequencer.sv
// wb_config_sequencer: Wishbone-driven serial loader for per-column fabric config chains.
// Defining CFG_READBACK_EN captures the chain tail into READBACK while each word shifts.
module wb_config_sequencer #(
   parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
   parameter int          NUM_COLS   = 4,
   parameter int          WORD_W     = 32,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic                wb_clk_i,
   input  logic                wb_rst_i,
   input  logic                wbs_stb_i,
   input  logic                wbs_cyc_i,
   input  logic                wbs_we_i,
   input  logic [3:0]          wbs_sel_i,
   input  logic [31:0]         wbs_data_i,
   input  logic [31:0]         wbs_addr_i,
   output logic                wbs_ack_o,
   output logic [31:0]         wbs_data_o,
   output logic                cen,
   output logic [NUM_COLS-1:0] cfg_data_out,
   output logic [NUM_COLS-1:0] shift_out,
   output logic [NUM_COLS-1:0] set_out,
   input  logic [NUM_COLS-1:0] cfg_data_in
);
   localparam int CW = NUM_COLS > 1 ? $clog2(NUM_COLS) : 1;
   localparam int AW = $clog2(FIFO_DEPTH);
   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, SET} state_t;
   state_t                state;
   logic [CW+WORD_W-1:0]  mem [FIFO_DEPTH];
   logic [AW-1:0]         wp, rp;
   logic [AW:0]           lvl;
   logic [CW-1:0]         col, col_l, set_col, wcol, ecol;
   logic [WORD_W-1:0]     sh, sh_n, edata;
   logic [5:0]            cnt;
   logic [15:0]           done;
   logic                  set_pend, err, full, empty, busy, pop, push, req, dwr, go, col_ok, flush;
   logic [7:0]            off;
   logic [31:0]           rd, ctrl_v, status_v, rb_v;
   logic [NUM_COLS-1:0]   mask_l, emask, set_mask;
   logic                  unused_ok;
   assign off      = wbs_addr_i[7:0];
   assign full     = lvl == (AW+1)'(FIFO_DEPTH);
   assign empty    = lvl == 0;
   assign busy     = state != IDLE || !empty || set_pend;
   assign pop      = state == LOAD && !empty;
   assign req      = wbs_stb_i && wbs_cyc_i && !wbs_ack_o && wbs_addr_i[31:8] == BASE_ADDR[31:8];
   assign dwr      = wbs_we_i && off == 8'h04;
   // a DATA write into a full FIFO waits, unless the engine frees a slot this very cycle
   assign go       = req && !(dwr && full && !pop);
   assign push     = go && dwr;
   assign flush    = go && wbs_we_i && off == 8'h00 && wbs_data_i[10];
   assign col_ok   = {24'b0, wbs_data_i[7:0]} < NUM_COLS;
   assign wcol     = col_ok ? wbs_data_i[CW-1:0] : col;
   assign {ecol, edata} = mem[rp];
   assign sh_n     = sh >> 1;
   assign mask_l   = NUM_COLS'(1) << col_l;
   assign emask    = NUM_COLS'(1) << ecol;
   assign set_mask = NUM_COLS'(1) << set_col;
   assign ctrl_v   = {23'b0, cen, 8'(col)};
   assign status_v = {done, 8'(lvl), 3'b0, err, set_pend, empty, full, busy};
`ifdef CFG_READBACK_EN
   logic [WORD_W-1:0] rb;
   assign rb_v      = 32'(rb);
   assign unused_ok = ^{wbs_sel_i, wbs_data_i};
`else
   assign rb_v      = 32'd0;
   assign unused_ok = ^{wbs_sel_i, wbs_data_i, cfg_data_in};
`endif
   always_comb begin
      rd = off == 8'h00 ? ctrl_v : off == 8'h08 ? status_v : off == 8'h0C ? rb_v : 32'd0;
   end
   always_ff @(posedge wb_clk_i) begin
      if (push) mem[wp] <= {col, wbs_data_i[WORD_W-1:0]};
   end
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state        <= IDLE;
         wp           <= '0;
         rp           <= '0;
         lvl          <= '0;
         col          <= '0;
         col_l        <= '0;
         set_col      <= '0;
         sh           <= '0;
         cnt          <= '0;
         done         <= '0;
         set_pend     <= 1'b0;
         err          <= 1'b0;
         cen          <= 1'b0;
         wbs_ack_o    <= 1'b0;
         wbs_data_o   <= '0;
         cfg_data_out <= '0;
         shift_out    <= '0;
         set_out      <= '0;
`ifdef CFG_READBACK_EN
         rb           <= '0;
`endif
      end else begin
         wbs_ack_o  <= go;
         wbs_data_o <= go && !wbs_we_i ? rd : 32'd0;
         if (push) wp <= wp + 1'b1;
         if (pop) rp <= rp + 1'b1;
         lvl <= lvl + (AW+1)'(push) - (AW+1)'(pop);
         case (state)
            IDLE:
               if (!empty) state <= LOAD;
               else if (set_pend) begin
                  state    <= SET;
                  set_out  <= set_mask;
                  set_pend <= 1'b0;
               end
            LOAD:
               if (pop) begin
                  state        <= SHIFT;
                  sh           <= edata;
                  col_l        <= ecol;
                  cnt          <= '0;
                  shift_out    <= emask;
                  cfg_data_out <= edata[0] ? emask : '0;
               end else state <= IDLE;
            SHIFT: begin
`ifdef CFG_READBACK_EN
               rb <= (rb >> 1) | (WORD_W'(cfg_data_in[col_l]) << (WORD_W-1));
`endif
               if (cnt == 6'(WORD_W-1)) begin
                  state        <= IDLE;
                  shift_out    <= '0;
                  cfg_data_out <= '0;
                  done         <= done + 1'b1;
               end else begin
                  cnt          <= cnt + 1'b1;
                  sh           <= sh_n;
                  cfg_data_out <= sh_n[0] ? mask_l : '0;
               end
            end
            SET: begin
               set_out <= '0;
               state   <= IDLE;
            end
         endcase
         if (go && wbs_we_i && off == 8'h00) begin
            cen <= wbs_data_i[8];
            if (col_ok) col <= wbs_data_i[CW-1:0];
            else err <= 1'b1;
            if (wbs_data_i[9] && !set_pend) begin
               set_pend <= 1'b1;
               set_col  <= wcol;
            end
         end
         if (go && wbs_we_i && off == 8'h08 && wbs_data_i[4]) err <= 1'b0;
         // flush drops queued words and any pending set; the word already loaded keeps shifting
         if (flush) begin
            wp       <= '0;
            rp       <= '0;
            lvl      <= '0;
            set_pend <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_wb_config_sequencer.sv
// tb_wb_config_sequencer: scoreboard bench for wb_config_sequencer (NUM_COLS=4, WORD_W=32, depth 4).
module tb_wb_config_sequencer;
   localparam int NC = 4;
   localparam int WW = 32;
   logic wb_clk_i = 1'b0, wb_rst_i = 1'b1;
   logic wbs_stb_i = 1'b0, wbs_cyc_i = 1'b0, wbs_we_i = 1'b0;
   logic [3:0] wbs_sel_i = 4'hF;
   logic [31:0] wbs_data_i = '0, wbs_addr_i = '0;
   logic wbs_ack_o, cen;
   logic [31:0] wbs_data_o;
   logic [NC-1:0] cfg_data_out, shift_out, set_out, cfg_data_in;
   logic [31:0] dl;
   int vectors = 0, miscompares = 0;
   logic [39:0] sb[$];
   logic [39:0] exp_w;
   logic [31:0] acc;
   logic [NC-1:0] cur, exp_mask, set_last;
   logic [7:0] m_col = 8'd0;
   int exp_cnt = 0, bits = 0, cycle = 0, set_cnt = 0, set_cyc = 0, last_shift_cyc = 0;
   logic just_done = 1'b0;

   wb_config_sequencer dut (
      .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i),
      .wbs_we_i(wbs_we_i), .wbs_sel_i(wbs_sel_i), .wbs_data_i(wbs_data_i), .wbs_addr_i(wbs_addr_i),
      .wbs_ack_o(wbs_ack_o), .wbs_data_o(wbs_data_o), .cen(cen), .cfg_data_out(cfg_data_out),
      .shift_out(shift_out), .set_out(set_out), .cfg_data_in(cfg_data_in));

   always #5 wb_clk_i = ~wb_clk_i;
   always @(posedge wb_clk_i) cycle++;

   // column 0 tail returns what was shifted in 32 bits earlier
   assign cfg_data_in = {{(NC-1){1'b0}}, dl[31]};
   always @(posedge wb_clk_i or posedge wb_rst_i)
      if (wb_rst_i) dl <= '0;
      else if (shift_out[0]) dl <= {dl[30:0], cfg_data_out[0]};

   always @(negedge wb_clk_i) begin
      if (wb_rst_i) begin
         bits = 0;
         just_done = 1'b0;
      end else begin
         if (|set_out) begin
            set_cnt++;
            set_last = set_out;
            set_cyc = cycle;
         end
         if (just_done && |shift_out) begin
            miscompares++;
            $display("FAIL word_len: shift_out %b still high after %0d bits", shift_out, WW);
         end
         just_done = 1'b0;
         if (|shift_out) begin
            if (bits == 0) cur = shift_out;
            else if (shift_out !== cur) begin
               miscompares++;
               $display("FAIL shift_strobe: got %b expected %b", shift_out, cur);
            end
            if ((cfg_data_out & ~shift_out) != '0) begin
               miscompares++;
               $display("FAIL idle_data: cfg_data_out %b outside strobe %b", cfg_data_out, shift_out);
            end
            acc[bits] = |(cfg_data_out & shift_out);
            bits++;
            if (bits == WW) begin
               vectors++;
               if (sb.size() == 0) begin
                  miscompares++;
                  $display("FAIL word: unexpected word %h on %b", acc, cur);
               end else begin
                  exp_w = sb.pop_front();
                  exp_mask = NC'(1) << exp_w[39:32];
                  if (acc !== exp_w[31:0] || cur !== exp_mask) begin
                     miscompares++;
                     $display("FAIL word: got %h on %b expected %h on %b", acc, cur, exp_w[31:0], exp_mask);
                  end
               end
               bits = 0;
               just_done = 1'b1;
               last_shift_cyc = cycle;
            end
         end else if (bits != 0) begin
            miscompares++;
            $display("FAIL word_len: strobe dropped after %0d bits", bits);
            bits = 0;
         end
      end
   end

   task automatic wb_xfer(input logic we, input logic [7:0] off, input logic [31:0] wd,
                          output logic [31:0] rdat, output int lat);
      @(negedge wb_clk_i);
      wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = we;
      wbs_addr_i = 32'h3000_0000 | {24'b0, off}; wbs_data_i = wd;
      lat = 0;
      rdat = '0;
      do begin
         @(negedge wb_clk_i);
         lat++;
      end while (!wbs_ack_o && lat < 200);
      if (!wbs_ack_o) begin
         miscompares++;
         $display("FAIL ack_timeout: off %h no ack after %0d cycles", off, lat);
      end
      rdat = wbs_data_o;
      wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
   endtask

   task automatic wb_wr(input logic [7:0] off, input logic [31:0] d, output int lat);
      logic [31:0] r;
      if (off == 8'h00 && d[7:0] < NC) m_col = d[7:0];
      if (off == 8'h04) begin
         sb.push_back({m_col, d});
         exp_cnt++;
      end
      wb_xfer(1'b1, off, d, r, lat);
   endtask

   task automatic wb_rd(input logic [7:0] off, output logic [31:0] d);
      int lat;
      wb_xfer(1'b0, off, 32'd0, d, lat);
   endtask

   task automatic wait_idle();
      logic [31:0] s;
      int n = 0;
      do begin
         wb_rd(8'h08, s);
         n++;
      end while (s[0] && n < 300);
      if (s[0]) begin
         miscompares++;
         $display("FAIL idle_timeout: STATUS %h still busy", s);
      end
   endtask

   task automatic test_reset();
      logic [31:0] r;
      repeat (3) @(negedge wb_clk_i);
      vectors++;
      if ({wbs_ack_o, wbs_data_o, cen, shift_out, set_out, cfg_data_out} !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs: ack %b data %h cen %b shift %b set %b cfg %b", wbs_ack_o, wbs_data_o, cen, shift_out, set_out, cfg_data_out);
      end
      wb_rst_i = 1'b0;
      wb_rd(8'h08, r);
      vectors++;
      if (r !== 32'h0000_0004) begin miscompares++; $display("FAIL reset_status: got %h expected %h", r, 32'h4); end
      wb_rd(8'h00, r);
      vectors++;
      if (r !== 32'h0) begin miscompares++; $display("FAIL reset_ctrl: got %h expected 0", r); end
      wb_rd(8'h0C, r);
      vectors++;
      if (r !== 32'h0) begin miscompares++; $display("FAIL reset_readback: got %h expected 0", r); end
      wb_rd(8'h10, r);
      vectors++;
      if (r !== 32'h0) begin miscompares++; $display("FAIL unmapped_read: got %h expected 0", r); end
   endtask

   task automatic test_basic();
      logic [31:0] r;
      int lat;
      wb_wr(8'h00, 32'h0000_0102, lat);
      vectors++;
      if (cen !== 1'b1) begin miscompares++; $display("FAIL basic_cen: got %b expected 1", cen); end
      wb_rd(8'h00, r);
      vectors++;
      if (r !== 32'h0000_0102) begin miscompares++; $display("FAIL basic_ctrl: got %h expected %h", r, 32'h102); end
      wb_wr(8'h04, 32'h0000_0005, lat);
      wait_idle();
      wb_rd(8'h08, r);
      vectors++;
      if (r !== {16'(exp_cnt), 16'h0004}) begin miscompares++; $display("FAIL basic_status: got %h expected %h", r, {16'(exp_cnt), 16'h0004}); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] r;
      int lat [6];
      for (int i = 0; i < 6; i++) wb_wr(8'h04, $urandom, lat[i]);
      for (int i = 0; i < 5; i++) begin
         vectors++;
         if (lat[i] !== 1) begin miscompares++; $display("FAIL b2b_ack%0d: latency %0d expected 1", i, lat[i]); end
      end
      vectors++;
      if (lat[5] <= 20) begin miscompares++; $display("FAIL b2b_stall: latency %0d expected >20", lat[5]); end
      wait_idle();
      wb_rd(8'h08, r);
      vectors++;
      if (r !== {16'(exp_cnt), 16'h0004}) begin miscompares++; $display("FAIL b2b_status: got %h expected %h", r, {16'(exp_cnt), 16'h0004}); end
   endtask

   task automatic test_set();
      logic [31:0] r;
      int lat, n0;
      n0 = set_cnt;
      wb_wr(8'h04, 32'hA5A5_0F0F, lat);
      wb_wr(8'h00, 32'h0000_0301, lat);
      wb_rd(8'h08, r);
      vectors++;
      if (r[3] !== 1'b1) begin miscompares++; $display("FAIL set_pending: got %b expected 1", r[3]); end
      wait_idle();
      vectors++;
      if (set_cnt - n0 !== 1 || set_last !== 4'b0010) begin miscompares++; $display("FAIL set_pulse: cycles %0d on %b expected 1 on 0010", set_cnt - n0, set_last); end
      vectors++;
      if (set_cyc - last_shift_cyc < 1 || set_cyc - last_shift_cyc > 2) begin miscompares++; $display("FAIL set_timing: gap %0d expected 1..2", set_cyc - last_shift_cyc); end
      wb_rd(8'h08, r);
      vectors++;
      if (r[3] !== 1'b0) begin miscompares++; $display("FAIL set_clear: got %b expected 0", r[3]); end
   endtask

   task automatic test_err();
      logic [31:0] r;
      int lat;
      wb_wr(8'h00, 32'h0000_0120, lat);
      wb_rd(8'h08, r);
      vectors++;
      if (r[4] !== 1'b1) begin miscompares++; $display("FAIL err_set: got %b expected 1", r[4]); end
      wb_rd(8'h00, r);
      vectors++;
      if (r !== 32'h0000_0101) begin miscompares++; $display("FAIL err_col: got %h expected %h", r, 32'h101); end
      wb_wr(8'h08, 32'h0000_0010, lat);
      wb_rd(8'h08, r);
      vectors++;
      if (r[4] !== 1'b0) begin miscompares++; $display("FAIL err_clear: got %b expected 0", r[4]); end
   endtask

   task automatic test_flush();
      logic [31:0] r;
      int lat;
      wb_wr(8'h04, 32'h1234_5678, lat);
      wb_wr(8'h04, 32'hDEAD_BEEF, lat);
      wb_wr(8'h04, 32'hCAFE_F00D, lat);
      void'(sb.pop_back());
      void'(sb.pop_back());
      exp_cnt -= 2;
      wb_wr(8'h00, 32'h0000_0501, lat);
      wait_idle();
      vectors++;
      if (sb.size() !== 0) begin miscompares++; $display("FAIL flush_inflight: %0d words missing expected 0", sb.size()); end
      wb_rd(8'h08, r);
      vectors++;
      if (r !== {16'(exp_cnt), 16'h0004}) begin miscompares++; $display("FAIL flush_status: got %h expected %h", r, {16'(exp_cnt), 16'h0004}); end
   endtask

   task automatic test_readback();
      logic [31:0] r, a;
      int lat;
      a = 32'h9C3E_51A7;
      wb_wr(8'h00, 32'h0000_0100, lat);
      wb_wr(8'h04, a, lat);
      wb_wr(8'h04, 32'h0F1E_2D3C, lat);
      wait_idle();
      wb_rd(8'h0C, r);
      vectors++;
`ifdef CFG_READBACK_EN
      if (r !== a) begin miscompares++; $display("FAIL readback: got %h expected %h", r, a); end
`else
      if (r !== 32'h0) begin miscompares++; $display("FAIL readback: got %h expected 0", r); end
`endif
   endtask

   task automatic test_reset_mid();
      logic [31:0] r;
      int lat, n;
      wb_wr(8'h04, 32'hFFFF_FFFF, lat);
      n = 0;
      do begin
         @(negedge wb_clk_i);
         #1;
         n++;
      end while (bits != 10 && n < 200);
      vectors++;
      if (bits != 10) begin miscompares++; $display("FAIL mid_reach: bits %0d expected 10", bits); end
      wb_rst_i = 1'b1;
      #1;
      vectors++;
      if ({shift_out, set_out, cfg_data_out, wbs_ack_o} !== '0) begin miscompares++; $display("FAIL mid_strobes: shift %b set %b cfg %b ack %b expected 0", shift_out, set_out, cfg_data_out, wbs_ack_o); end
      sb.delete();
      exp_cnt = 0;
      m_col = 8'd0;
      repeat (2) @(negedge wb_clk_i);
      wb_rst_i = 1'b0;
      wb_rd(8'h08, r);
      vectors++;
      if (r !== 32'h0000_0004) begin miscompares++; $display("FAIL mid_status: got %h expected %h", r, 32'h4); end
      wb_rd(8'h00, r);
      vectors++;
      if (r !== 32'h0) begin miscompares++; $display("FAIL mid_ctrl: got %h expected 0", r); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_set();
      test_err();
      test_flush();
      test_readback();
      test_reset_mid();
      repeat (50) @(negedge wb_clk_i);
      vectors++;
      if (shift_out !== '0 || sb.size() !== 0) begin miscompares++; $display("FAIL post_reset: shift %b pending %0d expected idle", shift_out, sb.size()); end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
